// File: rtl/uartrx_if.sv
// Receive-side bus of the UART receiver: serial line in, character and flags out.
interface uartrx_if;
  logic       rx;
  logic [7:0] dataout;
  logic       rdsig;
  logic       dataerror;
  logic       frameerror;
  logic       idle;

  modport master (output rx, input dataout, rdsig, dataerror, frameerror, idle);
  modport slave  (input rx, output dataout, rdsig, dataerror, frameerror, idle);
endinterface

// File: rtl/uartrx.sv
// UART receiver on a 16x-baud clock: 1 start, 8 data LSB first, optional
// parity, 1 stop. Each bit is sampled once at cnt==7 (mid-bit).
module uartrx #(
  parameter bit PARITY_EN  = 1'b0,
  parameter bit PARITY_ODD = 1'b0
) (
  input logic      clk,
  input logic      rst,
  uartrx_if.slave  bus
);

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_BREAK
  } state_e;

  state_e     state_q;
  logic       rx_meta_q, rx_s_q;
  logic [3:0] cnt_q, cnt_d;
  logic [3:0] bit_idx_q;
  logic [7:0] shift_q, shift_d;
  logic       perr_q, perr_d;
  logic       mid_bit;
  logic [7:0] dataout_q;
  logic       rdsig_q, dataerror_q, frameerror_q, idle_q;

  // Two-flop synchronizer; resets to the idle (high) line level.
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
    end else begin
      rx_meta_q <= bus.rx;
      rx_s_q    <= rx_meta_q;
    end
  end

  // Next-value helpers shared by several states.
  always_comb begin
    cnt_d   = cnt_q + 4'd1;
    mid_bit = (cnt_q == 4'd7);
    shift_d = {rx_s_q, shift_q[7:1]};
    perr_d  = (^shift_q) ^ rx_s_q ^ PARITY_ODD;
  end

  // Frame FSM with registered outputs; strobes default low every cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      cnt_q        <= 4'd0;
      bit_idx_q    <= 4'd0;
      shift_q      <= 8'h00;
      perr_q       <= 1'b0;
      dataout_q    <= 8'h00;
      rdsig_q      <= 1'b0;
      dataerror_q  <= 1'b0;
      frameerror_q <= 1'b0;
      idle_q       <= 1'b1;
    end else begin
      rdsig_q      <= 1'b0;
      dataerror_q  <= 1'b0;
      frameerror_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          cnt_q     <= 4'd0;
          bit_idx_q <= 4'd0;
          perr_q    <= 1'b0;
          if (!rx_s_q) begin
            state_q <= S_START;
            idle_q  <= 1'b0;
          end
        end
        S_START: begin
          cnt_q <= cnt_d;
          if (mid_bit) begin
            if (rx_s_q) begin
              // Start bit gone by mid-bit: treat as a glitch.
              state_q <= S_IDLE;
              cnt_q   <= 4'd0;
              idle_q  <= 1'b1;
            end else begin
              state_q <= S_DATA;
            end
          end
        end
        S_DATA: begin
          cnt_q <= cnt_d;
          if (mid_bit) begin
            shift_q   <= shift_d;
            bit_idx_q <= bit_idx_q + 4'd1;
            if (bit_idx_q == 4'd7)
              state_q <= PARITY_EN ? S_PARITY : S_STOP;
          end
        end
        S_PARITY: begin
          cnt_q <= cnt_d;
          if (mid_bit) begin
            perr_q  <= perr_d;
            state_q <= S_STOP;
          end
        end
        S_STOP: begin
          cnt_q <= cnt_d;
          if (mid_bit) begin
            dataout_q    <= shift_q;
            rdsig_q      <= 1'b1;
            frameerror_q <= ~rx_s_q;
            dataerror_q  <= PARITY_EN ? perr_q : 1'b0;
            // Leave at mid-stop so a back-to-back start edge is not missed.
            if (rx_s_q) begin
              state_q <= S_IDLE;
              cnt_q   <= 4'd0;
              idle_q  <= 1'b1;
            end else begin
              state_q <= S_BREAK;
            end
          end
        end
        S_BREAK: begin
          // Held-low line must return high before a new start can be seen.
          cnt_q <= 4'd0;
          if (rx_s_q) begin
            state_q <= S_IDLE;
            idle_q  <= 1'b1;
          end
        end
        default: begin
          state_q <= S_IDLE;
          cnt_q   <= 4'd0;
          idle_q  <= 1'b1;
        end
      endcase
    end
  end

  assign bus.dataout    = dataout_q;
  assign bus.rdsig      = rdsig_q;
  assign bus.dataerror  = dataerror_q;
  assign bus.frameerror = frameerror_q;
  assign bus.idle       = idle_q;

endmodule

// File: tb/tb_uartrx.sv
// Directed bench for uartrx: dut0 without parity, dut1 with odd parity.
module tb_uartrx;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rx0 = 1'b1;
  logic rx1 = 1'b1;
  int   cyc = 0;
  int   n_tests = 0;
  int   n_fail  = 0;

  uartrx_if if0();
  uartrx_if if1();
  assign if0.rx = rx0;
  assign if1.rx = rx1;

  uartrx u0 (.clk(clk), .rst(rst), .bus(if0.slave));
  uartrx #(.PARITY_EN(1'b1), .PARITY_ODD(1'b1)) u1 (.clk(clk), .rst(rst), .bus(if1.slave));

  always #5 clk = ~clk;

  // Edge number: value of cyc seen at the negedge following that rising edge.
  always @(posedge clk) cyc <= cyc + 1;

  // rdsig log per dut: edge, data, flags, and idle one cycle later.
  int         rd0_n = 0, rd1_n = 0;
  logic       rd0_pend = 1'b0;
  int         log0_edge [32];
  logic [7:0] log0_data [32];
  logic       log0_fe [32], log0_de [32], log0_idle [32];
  int         log1_edge [32];
  logic [7:0] log1_data [32];
  logic       log1_fe [32], log1_de [32];

  always @(negedge clk) begin
    if (if0.rdsig === 1'b1) begin
      if (rd0_n < 32) begin
        log0_edge[rd0_n] <= cyc;
        log0_data[rd0_n] <= if0.dataout;
        log0_fe[rd0_n]   <= if0.frameerror;
        log0_de[rd0_n]   <= if0.dataerror;
      end
      rd0_n <= rd0_n + 1;
    end
    if (rd0_pend && rd0_n >= 1 && rd0_n <= 32) log0_idle[rd0_n-1] <= if0.idle;
    rd0_pend <= (if0.rdsig === 1'b1);
    if (if1.rdsig === 1'b1) begin
      if (rd1_n < 32) begin
        log1_edge[rd1_n] <= cyc;
        log1_data[rd1_n] <= if1.dataout;
        log1_fe[rd1_n]   <= if1.frameerror;
        log1_de[rd1_n]   <= if1.dataerror;
      end
      rd1_n <= rd1_n + 1;
    end
  end

  // Advance n cycles, landing just after a negedge (far from the active edge).
  task automatic tick(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  task automatic set_rx(input int sel, input logic v);
    if (sel == 0) rx0 = v; else rx1 = v;
  endtask

  // Drive one frame; e0 is the first rising edge that sees the start bit.
  task automatic drive_frame(input int sel, input logic [7:0] d, input bit par_en,
                             input logic par, input logic stop, output int e0);
    e0 = cyc + 1;
    set_rx(sel, 1'b0); tick(16);
    for (int i = 0; i < 8; i++) begin set_rx(sel, d[i]); tick(16); end
    if (par_en) begin set_rx(sel, par); tick(16); end
    set_rx(sel, stop); tick(16);
  endtask

  task automatic test_reset();
    rst = 1'b1; tick(3);
    n_tests++;
    if (if0.dataout !== 8'h00 || if0.rdsig !== 1'b0 || if0.dataerror !== 1'b0 ||
        if0.frameerror !== 1'b0 || if0.idle !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_dut0: got data=%h rd=%b de=%b fe=%b idle=%b, want 00 0 0 0 1",
               if0.dataout, if0.rdsig, if0.dataerror, if0.frameerror, if0.idle);
    end
    n_tests++;
    if (if1.dataout !== 8'h00 || if1.rdsig !== 1'b0 || if1.idle !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_dut1: got data=%h rd=%b idle=%b, want 00 0 1",
               if1.dataout, if1.rdsig, if1.idle);
    end
    rst = 1'b0; tick(4);
  endtask

  task automatic test_frame_55();
    int e0, n0;
    n0 = rd0_n;
    drive_frame(0, 8'h55, 1'b0, 1'b0, 1'b1, e0);
    tick(4);
    n_tests++;
    if (rd0_n !== n0 + 1) begin
      n_fail++; $display("FAIL f55_count: got %0d pulses, want 1", rd0_n - n0);
    end else begin
      n_tests++;
      if (log0_edge[n0] !== e0 + 154) begin
        n_fail++; $display("FAIL f55_edge: got E%0d, want E154", log0_edge[n0] - e0);
      end
      n_tests++;
      if (log0_data[n0] !== 8'h55 || log0_fe[n0] !== 1'b0 || log0_de[n0] !== 1'b0) begin
        n_fail++;
        $display("FAIL f55_data: got %h fe=%b de=%b, want 55 0 0",
                 log0_data[n0], log0_fe[n0], log0_de[n0]);
      end
      n_tests++;
      if (log0_idle[n0] !== 1'b1) begin
        n_fail++; $display("FAIL f55_idle: got idle=%b at E155, want 1", log0_idle[n0]);
      end
    end
  endtask

  task automatic test_glitch();
    int e0, n0;
    n0 = rd0_n;
    e0 = cyc + 1;
    rx0 = 1'b0; tick(4);
    rx0 = 1'b1; tick(6);
    n_tests++;
    if (if0.idle !== 1'b0) begin
      n_fail++; $display("FAIL glitch_start: got idle=%b after E9, want 0", if0.idle);
    end
    tick(1);
    n_tests++;
    if (if0.idle !== 1'b1) begin
      n_fail++; $display("FAIL glitch_idle: got idle=%b after E10, want 1", if0.idle);
    end
    tick(200);
    n_tests++;
    if (rd0_n !== n0) begin
      n_fail++; $display("FAIL glitch_rdsig: got %0d pulses, want 0", rd0_n - n0);
    end
  endtask

  task automatic test_break();
    int e0, n0;
    n0 = rd0_n;
    drive_frame(0, 8'hA5, 1'b0, 1'b0, 1'b0, e0);
    tick(64);
    n_tests++;
    if (rd0_n !== n0 + 1) begin
      n_fail++; $display("FAIL brk_count: got %0d pulses, want 1", rd0_n - n0);
    end else begin
      n_tests++;
      if (log0_edge[n0] !== e0 + 154 || log0_data[n0] !== 8'hA5 ||
          log0_fe[n0] !== 1'b1 || log0_de[n0] !== 1'b0) begin
        n_fail++;
        $display("FAIL brk_frame: got E%0d %h fe=%b de=%b, want E154 a5 1 0",
                 log0_edge[n0] - e0, log0_data[n0], log0_fe[n0], log0_de[n0]);
      end
    end
    n_tests++;
    if (if0.idle !== 1'b0) begin
      n_fail++; $display("FAIL brk_hold_idle: got idle=%b while line low, want 0", if0.idle);
    end
    rx0 = 1'b1; tick(20);
    n_tests++;
    if (if0.idle !== 1'b1 || rd0_n !== n0 + 1) begin
      n_fail++;
      $display("FAIL brk_release: got idle=%b pulses=%0d, want 1 1", if0.idle, rd0_n - n0);
    end
  endtask

  task automatic test_back_to_back();
    int e0, e1, n0;
    n0 = rd0_n;
    drive_frame(0, 8'hA5, 1'b0, 1'b0, 1'b1, e0);
    drive_frame(0, 8'h3C, 1'b0, 1'b0, 1'b1, e1);
    tick(4);
    n_tests++;
    if (rd0_n !== n0 + 2) begin
      n_fail++; $display("FAIL b2b_count: got %0d pulses, want 2", rd0_n - n0);
    end else begin
      n_tests++;
      if (log0_edge[n0] !== e0 + 154 || log0_edge[n0+1] !== e0 + 314) begin
        n_fail++;
        $display("FAIL b2b_edges: got E%0d E%0d, want E154 E314",
                 log0_edge[n0] - e0, log0_edge[n0+1] - e0);
      end
      n_tests++;
      if (log0_data[n0] !== 8'hA5 || log0_data[n0+1] !== 8'h3C ||
          log0_fe[n0] !== 1'b0 || log0_fe[n0+1] !== 1'b0 ||
          log0_de[n0] !== 1'b0 || log0_de[n0+1] !== 1'b0) begin
        n_fail++;
        $display("FAIL b2b_data: got %h/%h fe=%b%b de=%b%b, want a5/3c 00 00",
                 log0_data[n0], log0_data[n0+1], log0_fe[n0], log0_fe[n0+1],
                 log0_de[n0], log0_de[n0+1]);
      end
    end
  endtask

  // 0x07 has three ones; with odd parity a parity bit of 0 is correct.
  task automatic test_parity(input logic par, input logic exp_de);
    int e0, n0;
    n0 = rd1_n;
    drive_frame(1, 8'h07, 1'b1, par, 1'b1, e0);
    tick(4);
    n_tests++;
    if (rd1_n !== n0 + 1) begin
      n_fail++; $display("FAIL par%0b_count: got %0d pulses, want 1", par, rd1_n - n0);
    end else begin
      n_tests++;
      if (log1_edge[n0] !== e0 + 170) begin
        n_fail++; $display("FAIL par%0b_edge: got E%0d, want E170", par, log1_edge[n0] - e0);
      end
      n_tests++;
      if (log1_data[n0] !== 8'h07 || log1_de[n0] !== exp_de || log1_fe[n0] !== 1'b0) begin
        n_fail++;
        $display("FAIL par%0b_flags: got %h de=%b fe=%b, want 07 %b 0",
                 par, log1_data[n0], log1_de[n0], log1_fe[n0], exp_de);
      end
    end
  endtask

  task automatic test_reset_midframe();
    int e0, n0;
    n0 = rd0_n;
    e0 = cyc + 1;
    rx0 = 1'b0; tick(16);
    tick(48);
    rx0 = 1'b1; rst = 1'b1; tick(1);
    rst = 1'b0;
    n_tests++;
    if (if0.dataout !== 8'h00 || if0.rdsig !== 1'b0 || if0.dataerror !== 1'b0 ||
        if0.frameerror !== 1'b0 || if0.idle !== 1'b1) begin
      n_fail++;
      $display("FAIL rstmid_outputs: got data=%h rd=%b de=%b fe=%b idle=%b, want 00 0 0 0 1",
               if0.dataout, if0.rdsig, if0.dataerror, if0.frameerror, if0.idle);
    end
    tick(200);
    n_tests++;
    if (rd0_n !== n0) begin
      n_fail++; $display("FAIL rstmid_rdsig: got %0d pulses, want 0", rd0_n - n0);
    end
    drive_frame(0, 8'h81, 1'b0, 1'b0, 1'b1, e0);
    tick(4);
    n_tests++;
    if (rd0_n !== n0 + 1) begin
      n_fail++; $display("FAIL rstmid_next_count: got %0d pulses, want 1", rd0_n - n0);
    end else begin
      n_tests++;
      if (log0_data[n0] !== 8'h81 || log0_edge[n0] !== e0 + 154 || log0_fe[n0] !== 1'b0) begin
        n_fail++;
        $display("FAIL rstmid_next: got %h E%0d fe=%b, want 81 E154 0",
                 log0_data[n0], log0_edge[n0] - e0, log0_fe[n0]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_frame_55();
    test_glitch();
    test_break();
    tick(10);
    test_back_to_back();
    tick(10);
    test_parity(1'b0, 1'b0);
    tick(10);
    test_parity(1'b1, 1'b1);
    tick(10);
    test_reset_midframe();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/uartrx.md
# uartrx

Asynchronous serial receiver: the receive-side counterpart of `uarttx` on the same link. It runs on the 16×-baud clock from `clkdiv` and samples the `rx` line, using the same clock-enable cadence as the transmitter. It delivers each received 8-bit character on `dataout` with a one-cycle `rdsig` strobe, plus framing and parity flags. Frame format: 1 start bit, 8 data bits LSB first, an optional parity bit, and 1 stop bit.

## Interface
Parameters:
- `PARITY_EN`, default 0: 1 means a parity bit follows bit 7.
- `PARITY_ODD`, default 0: 0 selects even parity, 1 selects odd. Ignored when `PARITY_EN`=0.

Ports:
- `clk`, in, 1: single clock, 16× the baud rate. All logic is on its rising edge.
- `rst`, in, 1: synchronous, active-high reset.
- `rx`, in, 1: serial line, asynchronous to `clk`. Idles high.
- `dataout`, out, 8: last received character. Holds until the next frame completes.
- `rdsig`, out, 1: one-cycle pulse; the frame is complete and `dataout` is valid.
- `dataerror`, out, 1: parity mismatch, valid while `rdsig`=1. Always 0 when `PARITY_EN`=0.
- `frameerror`, out, 1: stop bit sampled low, valid while `rdsig`=1.
- `idle`, out, 1: high in the IDLE state only.

## Operation
- Input synchronizer: `rx` passes through two flip-flops to give `rx_s`. Both flip-flops reset to 1. All decisions use `rx_s` only.
- Bit timing: a 4-bit counter `cnt` counts 0..15 per bit period. Sampling happens when `cnt`=7, roughly mid-bit. The counter wraps 15→0 and marks each bit boundary.
- Bit index: a 4-bit counter tracks the current bit.
- Shift register: 8 bits. Each data bit enters at bit 7 and shifts right, so after 8 samples the first bit received sits in bit 0 (LSB first).
- State machine:
  - IDLE: `idle`=1, `cnt`=0. When `rx_s`=0, go to START.
  - START: count `cnt`. At `cnt`=7:
    - `rx_s`=1 means a glitch: return to IDLE, no output.
    - `rx_s`=0: go to DATA with `cnt` continuing.
  - DATA: at each `cnt`=7, shift in `rx_s`. After the 8th sample, go to PARITY if `PARITY_EN`=1, else STOP.
  - PARITY: at `cnt`=7, compute the error:
    - even parity: error = XOR of the 8 data bits XOR the parity bit;
    - odd parity: the inverse of that.
    - Latch the result internally and go to STOP.
  - STOP: at `cnt`=7, load `dataout` from the shift register and pulse `rdsig`. Drive `frameerror` = ~`rx_s` and drive `dataerror` from the latched parity result. Then:
    - `rx_s`=1: go to IDLE.
    - `rx_s`=0: go to BREAK.
  - BREAK: `idle`=0. Wait until `rx_s`=1, then go to IDLE. A line held low after a bad stop bit never re-triggers a start.
- Back-to-back frames: leaving STOP at the mid-stop-bit sample leaves half a bit of margin. A new start edge arriving right after the stop bit is caught.
- Error flags do not suppress data. `dataout` updates on every completed frame, including errored ones; `rdsig` still pulses.
- Reset values: `dataout`=0x00, `rdsig`=0, `dataerror`=0, `frameerror`=0, `idle`=1, state IDLE, counters 0, shift register 0.
- Reset mid-frame: the state returns to IDLE on the next edge and the partial frame is discarded with no `rdsig`. If `rx` is still low after `rst` falls, the receiver enters START. Idle-line resync is the link's responsibility.

## Timing
- Edge numbering: E0 is the first rising edge at which the `rx` pin is low. `rx_s`=0 after E1. IDLE→START happens at E2.
- Start bit sample at E10, reflecting the pin at E8, about half a bit after the fall.
- Data bit i (i = 0..7) sampled at E10+16·(i+1).
- Parity bit (if enabled) sampled at E154.
- Stop bit sampled at E154, or E170 with parity enabled.
- `rdsig`, `dataout`, `dataerror` and `frameerror` are all registered at the stop-sample edge. They are visible for exactly one cycle after it.
- `rdsig` is high for 1 cycle. The error flags return to 0 on the next cycle.
- Minimum glitch rejected: any low pulse on `rx` that is gone before E8.
- Throughput: one frame per 160 clocks (176 with parity). There is no backpressure; the consumer must take `dataout` before the next `rdsig`.

## Test plan
- Send frame 0x55, `PARITY_EN`=0, fall placed just before E0 → exactly one `rdsig` pulse, registered at E154. `dataout`=0x55, `frameerror`=0, `idle` high again by E155.
- Drive `rx` low for 4 clocks only → no `rdsig`, state back to IDLE at E10, `idle`=1.
- Send 0xA5 with the stop bit driven 0, then hold `rx` low for 64 clocks → `rdsig`=1 with `frameerror`=1 and `dataout`=0xA5. No further `rdsig` until `rx` returns high and a new frame arrives.
- Send back-to-back 0xA5 then 0x3C with no idle gap → two `rdsig` pulses 160 clocks apart, carrying 0xA5 then 0x3C, with no errors.
- Set `PARITY_EN`=1, `PARITY_ODD`=1:
  - send 0x07 with parity bit 0 → `dataerror`=0;
  - send 0x07 with parity bit 1 → `dataerror`=1 and `dataout`=0x07.
  - In both cases `rdsig` is registered at E170.
- Assert `rst` for 1 cycle at the 4th data bit with `rx` then returned high → no `rdsig`, all outputs at reset values. A subsequent 0x81 frame is received correctly.
